// File: rtl/int2flt_if.sv
// rtl/int2flt_if.sv - start/done handshake and byte-wide data memory bus of the int-to-half converter
interface int2flt_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;

    modport master (
        input  start,
        input  mem_rd_data,
        output done,
        output mem_addr,
        output mem_wr_data,
        output mem_wr_en
    );

    modport slave (
        output start,
        output mem_rd_data,
        input  done,
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_en
    );
endinterface

// File: rtl/int2flt_core.sv
// rtl/int2flt_core.sv - sequential int16 to IEEE-754 half converter, one normalize shift per cycle, RNE
module int2flt_core #(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    int2flt_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_ABS,
        S_NORM,
        S_ROUND,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] SRC_ADDR_HI = 8'(SRC_ADDR + 8'd1);
    localparam logic [7:0] DST_ADDR_HI = 8'(DST_ADDR + 8'd1);

    state_t      state_q;
    state_t      state_d;
    logic        start_q;

    // Bus outputs are registered: values computed for a state appear during the following cycle.
    logic        done_q;
    logic        done_d;
    logic [7:0]  addr_q;
    logic [7:0]  addr_d;
    logic [7:0]  wr_data_q;
    logic [7:0]  wr_data_d;
    logic        wr_en_q;
    logic        wr_en_d;

    logic [7:0]  in_lo_q;
    logic [7:0]  in_hi_q;
    logic        sign_q;
    logic [15:0] mag_q;
    logic [4:0]  exp_q;
    logic [15:0] result_q;

    logic [15:0] x_in;
    logic [15:0] abs_mag;
    logic [9:0]  mant_trunc;
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [10:0] mant_sum;
    logic [9:0]  mant_final;
    logic [4:0]  exp_final;

    assign bus.done        = done_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_wr_en   = wr_en_q;

    // 0x8000 negates to itself, which read as unsigned is the required magnitude 32768.
    assign x_in    = {in_hi_q, in_lo_q};
    assign abs_mag = x_in[15] ? 16'(-x_in) : x_in;

    assign mant_trunc = mag_q[14:5];
    assign guard_bit  = mag_q[4];
    assign sticky_bit = |mag_q[3:0];
    assign round_up   = guard_bit && (sticky_bit || mant_trunc[0]);
    assign mant_sum   = {1'b0, mant_trunc} + {10'd0, round_up};

    // Largest magnitude gives exp 30, so the carry increment cannot reach the infinity code.
    always_comb begin
        mant_final = mant_sum[9:0];
        exp_final  = exp_q;
        if (mant_sum[10]) begin
            mant_final = 10'd0;
            exp_final  = 5'(exp_q + 5'd1);
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        addr_d    = SRC_ADDR;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_q && !bus.start) begin
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                addr_d  = SRC_ADDR_HI;
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                state_d = S_ABS;
            end
            S_ABS: begin
                state_d = (abs_mag == 16'd0) ? S_WR_LO : S_NORM;
            end
            S_NORM: begin
                if (mag_q[15]) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                addr_d    = DST_ADDR;
                wr_data_d = result_q[7:0];
                wr_en_d   = 1'b1;
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                addr_d    = DST_ADDR_HI;
                wr_data_d = result_q[15:8];
                wr_en_d   = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= SRC_ADDR;
            wr_data_q <= 8'd0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.start;
            done_q    <= done_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_lo_q  <= 8'd0;
            in_hi_q  <= 8'd0;
            sign_q   <= 1'b0;
            mag_q    <= 16'd0;
            exp_q    <= 5'd0;
            result_q <= 16'd0;
        end else begin
            case (state_q)
                S_RD_LO: in_lo_q <= bus.mem_rd_data;
                S_RD_HI: in_hi_q <= bus.mem_rd_data;
                S_ABS: begin
                    sign_q <= x_in[15];
                    mag_q  <= abs_mag;
                    exp_q  <= 5'd30;
                    if (abs_mag == 16'd0) begin
                        result_q <= 16'h0000;
                    end
                end
                S_NORM: begin
                    if (!mag_q[15]) begin
                        mag_q <= {mag_q[14:0], 1'b0};
                        exp_q <= 5'(exp_q - 5'd1);
                    end
                end
                S_ROUND: result_q <= {sign_q, exp_final, mant_final};
                default: ;
            endcase
        end
    end

endmodule
